line_buffer_ctrl: RTL and testbench

//   Sequences a bank of 4 external single-line buffers (8-bit grayscale, LINE_W px each) for 3x3 kernel filtering.

---
 rtl/line_buffer_ctrl.sv | 146 ++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
//   Sequences four external single-line buffers for a 3x3 kernel. Incoming
//   pixels are steered round-robin into the buffers, one image line per
//   buffer. Once three full lines are held, one read pass walks the three
//   oldest buffers in lockstep and assembles a 72-bit window per strobe.
//   Each finished read pass frees one buffer, which is signalled on o_intr.
//
// Ports
//   i_clk / i_rst_n    clock (rising edge) / async active-low reset
//   i_pixel_data/valid incoming pixel stream
//   o_lb_data          registered pixel to the buffers
//   o_lb_wr_en         one-hot write enable, buffer[wr_buf]
//   o_lb_rd_en         read-advance strobe, three bits set per read
//   i_lb_data          {buf3,buf2,buf1,buf0}, 24b (3 px) each
//   i_window_ready     downstream accepts a window this cycle
//   o_window           {oldest, middle, newest} row, 24b each
//   o_window_valid     one-cycle pulse per window
//   o_intr             one-cycle pulse per fully consumed line
//   o_overflow         sticky: pixel dropped because all buffers were full
module line_buffer_ctrl #(
  parameter int LINE_W = 512,
  parameter int CNT_W  = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_pixel_data,
  input  logic        i_pixel_valid,
  output logic [7:0]  o_lb_data,
  output logic [3:0]  o_lb_wr_en,
  output logic [3:0]  o_lb_rd_en,
  input  logic [95:0] i_lb_data,
  input  logic        i_window_ready,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  output logic        o_intr,
  output logic        o_overflow
);
  localparam int PXW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [PXW-1:0]   PX_LAST = PXW'(LINE_W - 1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(4 * LINE_W);
  localparam logic [CNT_W-1:0] OCC_RD   = CNT_W'(3 * LINE_W);

  typedef enum logic {S_IDLE, S_READ} state_e;

  state_e           state_q;
  logic [1:0]       wr_buf_q, rd_buf_q;
  logic [PXW-1:0]   wr_px_q, rd_px_q;
  logic [CNT_W-1:0] occ_q;
  logic [7:0]       lb_data_q;
  logic [3:0]       lb_wr_en_q;
  logic [71:0]      window_q;
  logic             window_valid_q, intr_q, overflow_q;

  logic             full, accept, rd, rd_last;
  logic [3:0]       rd_mask;
  logic [3:0][23:0] lb_px;
  logic [2:0][23:0] rows;

  assign full    = (occ_q == OCC_FULL);
  assign accept  = i_pixel_valid && !full;
  assign rd      = (state_q == S_READ) && i_window_ready;
  assign rd_last = rd && (rd_px_q == PX_LAST);
  assign lb_px   = i_lb_data;

  // Row r of the window comes from buffer rd_buf+r; row 0 (oldest) lands in
  // the top 24 bits. Pointer addition wraps naturally on 2 bits.
  for (genvar r = 0; r < 3; r++) begin : g_row
    assign rows[2-r] = lb_px[rd_buf_q + 2'(r)];
  end

  always_comb begin
    rd_mask = '0;
    for (int k = 0; k < 3; k++) rd_mask[rd_buf_q + 2'(k)] = 1'b1;
  end

  // The read strobe must track i_window_ready in the same cycle, so it is
  // the only combinational output; it is gated by the registered state.
  assign o_lb_rd_en = rd ? rd_mask : 4'b0000;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_IDLE;
      wr_buf_q       <= '0;
      rd_buf_q       <= '0;
      wr_px_q        <= '0;
      rd_px_q        <= '0;
      occ_q          <= '0;
      lb_data_q      <= '0;
      lb_wr_en_q     <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      intr_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      // write side
      lb_data_q  <= i_pixel_data;
      lb_wr_en_q <= accept ? (4'b0001 << wr_buf_q) : 4'b0000;
      if (accept) begin
        if (wr_px_q == PX_LAST) begin
          wr_px_q  <= '0;
          wr_buf_q <= wr_buf_q + 2'd1;
        end else begin
          wr_px_q <= wr_px_q + PXW'(1);
        end
      end
      if (i_pixel_valid && full) overflow_q <= 1'b1;

      // occupancy: a write and a read in the same cycle cancel
      case ({accept, rd})
        2'b10:   occ_q <= occ_q + CNT_W'(1);
        2'b01:   occ_q <= occ_q - CNT_W'(1);
        default: occ_q <= occ_q;
      endcase

      // window capture uses the pointers before they advance
      window_valid_q <= rd;
      intr_q         <= rd_last;
      if (rd) window_q <= rows;

      // read FSM: one line per READ visit, always back through IDLE
      case (state_q)
        S_IDLE: if (occ_q >= OCC_RD) state_q <= S_READ;
        S_READ: begin
          if (rd) begin
            if (rd_last) begin
              rd_px_q  <= '0;
              rd_buf_q <= rd_buf_q + 2'd1;
              state_q  <= S_IDLE;
            end else begin
              rd_px_q <= rd_px_q + PXW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_lb_data      = lb_data_q;
  assign o_lb_wr_en     = lb_wr_en_q;
  assign o_window       = window_q;
  assign o_window_valid = window_valid_q;
  assign o_intr         = intr_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
module tb_line_buffer_ctrl;
  localparam int L  = 16;
  localparam int CW = 7;

  logic        clk, rst_n;
  logic [7:0]  pixel_data;
  logic        pixel_valid;
  logic [7:0]  lb_data_o;
  logic [3:0]  lb_wr_en, lb_rd_en;
  logic [95:0] lb_data_i;
  logic        window_ready;
  logic [71:0] window;
  logic        window_valid, intr, overflow;

  line_buffer_ctrl #(.LINE_W(L), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pixel_data(pixel_data), .i_pixel_valid(pixel_valid),
    .o_lb_data(lb_data_o), .o_lb_wr_en(lb_wr_en), .o_lb_rd_en(lb_rd_en),
    .i_lb_data(lb_data_i), .i_window_ready(window_ready),
    .o_window(window), .o_window_valid(window_valid),
    .o_intr(intr), .o_overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int n_intr, n_win;

  // Reference model in terms of totals: pixels accepted and strobes issued.
  // Buffer indices, pixel positions and occupancy all follow arithmetically.
  int          acc, strb;
  bit          reading, m_ovf;
  logic [3:0]  e_wr;
  logic [7:0]  e_dat;
  logic        e_wv, e_intr;
  logic [71:0] e_win;

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic [3:0] exp_wr;
    logic [7:0] exp_dat;
  } vec_t;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    acc = 0; strb = 0; reading = 0; m_ovf = 0;
    e_wr = '0; e_dat = '0; e_wv = 0; e_intr = 0; e_win = '0;
  endtask

  function automatic logic [23:0] sl(input logic [95:0] d, input int k);
    return d[(k % 4) * 24 +: 24];
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},  72'(lb_data_o),    72'd0);
    chk({tag, "_wr"},    72'(lb_wr_en),     72'd0);
    chk({tag, "_rd"},    72'(lb_rd_en),     72'd0);
    chk({tag, "_win"},   window,            72'd0);
    chk({tag, "_wv"},    72'(window_valid), 72'd0);
    chk({tag, "_intr"},  72'(intr),         72'd0);
    chk({tag, "_ovf"},   72'(overflow),     72'd0);
  endtask

  // One clock: drive, check the combinational strobe, step model, check regs.
  task automatic cyc(input logic pv, input logic [7:0] pd, input logic rdy);
    int occ, rbuf, rpx, wbuf;
    bit rd, accept;
    logic [3:0] exp_rd;
    pixel_valid  = pv;
    pixel_data   = pd;
    window_ready = rdy;
    lb_data_i    = {$urandom(), $urandom(), $urandom()};
    #1;
    occ  = acc - strb;
    rbuf = (strb / L) % 4;
    rpx  = strb % L;
    wbuf = (acc / L) % 4;
    rd   = reading && rdy;
    exp_rd = '0;
    if (rd) for (int k = 0; k < 3; k++) exp_rd[(rbuf + k) % 4] = 1'b1;
    chk("rd_en", 72'(lb_rd_en), 72'(exp_rd));
    accept = pv && (occ != 4 * L);
    e_wr   = accept ? 4'(1 << wbuf) : 4'd0;
    e_dat  = pd;
    e_wv   = rd;
    if (rd) e_win = {sl(lb_data_i, rbuf), sl(lb_data_i, rbuf + 1), sl(lb_data_i, rbuf + 2)};
    e_intr = rd && (rpx == L - 1);
    if (pv && !accept) m_ovf = 1;
    if (reading) begin
      if (rd && rpx == L - 1) reading = 0;
    end else if (occ >= 3 * L) begin
      reading = 1;
    end
    acc  += int'(accept);
    strb += int'(rd);
    @(posedge clk); #1;
    chk("wr_en",  72'(lb_wr_en),     72'(e_wr));
    chk("lb_data",72'(lb_data_o),    72'(e_dat));
    chk("wvalid", 72'(window_valid), 72'(e_wv));
    chk("window", window,            e_win);
    chk("intr",   72'(intr),         72'(e_intr));
    chk("ovf",    72'(overflow),     72'(m_ovf));
    if (intr) n_intr++;
    if (window_valid) n_win++;
  endtask

  // Reset with valid pixels present; outputs must stay quiet throughout.
  task automatic do_reset();
    rst_n = 1'b0;
    window_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pixel_valid = 1'b1;
      pixel_data  = 8'($urandom());
      @(posedge clk); #1;
      chk_zero("rst");
    end
    pixel_valid  = 1'b0;
    window_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_reset();
    n_intr = 0;
    n_win  = 0;
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{pv:1'b1, pd:8'hA5, exp_wr:4'b0001, exp_dat:8'hA5};
    tbl[1] = '{pv:1'b0, pd:8'h3C, exp_wr:4'b0000, exp_dat:8'h3C};
    tbl[2] = '{pv:1'b1, pd:8'h5A, exp_wr:4'b0001, exp_dat:8'h5A};
    tbl[3] = '{pv:1'b1, pd:8'hFF, exp_wr:4'b0001, exp_dat:8'hFF};

    rst_n = 1'b1; pixel_valid = 0; pixel_data = 0; window_ready = 0; lb_data_i = '0;
    m_reset();
    #2;
    do_reset();

    // short table right after reset: first buffer selected, data registered
    for (int i = 0; i < 4; i++) begin
      cyc(tbl[i].pv, tbl[i].pd, 1'b0);
      chk("tbl_wr",   72'(lb_wr_en),  72'(tbl[i].exp_wr));
      chk("tbl_data", 72'(lb_data_o), 72'(tbl[i].exp_dat));
    end

    // three lines then one full read pass with ready held high
    do_reset();
    for (int i = 0; i < 3 * L; i++) cyc(1'b1, 8'($urandom()), 1'b1);
    for (int i = 0; i < L + 4; i++) cyc(1'b0, 8'd0, 1'b1);
    chk("one_line_intr", 72'(n_intr), 72'd1);
    chk("one_line_win",  72'(n_win),  72'(L));

    // continuous L-line frame: every line but the last two gets read
    do_reset();
    for (int i = 0; i < L * L; i++) cyc(1'b1, 8'($urandom()), 1'b1);
    for (int i = 0; i < 6 * (L + 1); i++) cyc(1'b0, 8'd0, 1'b1);
    chk("frame_intr", 72'(n_intr),   72'(L - 2));
    chk("frame_ovf",  72'(overflow), 72'd0);

    // ready toggling every cycle: still exactly L windows for the line
    do_reset();
    for (int i = 0; i < 3 * L; i++) cyc(1'b1, 8'($urandom()), 1'(i % 2));
    for (int i = 0; i < 3 * L; i++) cyc(1'b0, 8'd0, 1'(i % 2));
    chk("toggle_win",  72'(n_win),  72'(L));
    chk("toggle_intr", 72'(n_intr), 72'd1);

    // fill all four buffers with no reads, then one more pixel is dropped
    do_reset();
    for (int i = 0; i < 4 * L; i++) cyc(1'b1, 8'($urandom()), 1'b0);
    chk("pre_ovf", 72'(overflow), 72'd0);
    cyc(1'b1, 8'h77, 1'b0);
    chk("ovf_drop_wr", 72'(lb_wr_en), 72'd0);
    chk("ovf_set",     72'(overflow), 72'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 2 * L; i++) cyc(1'b1, 8'($urandom()), 1'b1);
    chk("ovf_sticky", 72'(overflow), 72'd1);

    // reset in the middle of a read pass, then a clean restart
    do_reset();
    for (int i = 0; i < 3 * L; i++) cyc(1'b1, 8'($urandom()), 1'b1);
    for (int i = 0; i < 4 * L && !(reading && (strb % L) == 10); i++)
      cyc(1'b0, 8'd0, 1'b1);
    chk("midrd_reached", 72'(strb % L), 72'd10);
    window_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    @(posedge clk); #1;
    chk_zero("async_edge");
    do_reset();
    for (int i = 0; i < 3 * L; i++) cyc(1'b1, 8'($urandom()), 1'b1);
    for (int i = 0; i < L + 4; i++) cyc(1'b0, 8'd0, 1'b1);
    chk("restart_intr", 72'(n_intr), 72'd1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom()), 1'($urandom_range(0, 2) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
